// File: rtl/spi_master_mcp23s17_pkg.sv
// Shared types and constants for the MCP23S17-style SPI master.
// Contents:
//   state_t       - transaction FSM states
//   OPCODE_BASE   - fixed upper nibble of the opcode byte
//   REG_*         - register addresses used by the emulator
//   RESP_*        - emulator read responses for those registers
//   opcode_byte() - builds {OPCODE_BASE, dev, rw}
package mcp23s17_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP,
        DONE
    } state_t;

    localparam logic [3:0] OPCODE_BASE = 4'b0100;

    localparam logic [7:0] REG_IODIR = 8'h00;
    localparam logic [7:0] REG_IOCON = 8'h0A;
    localparam logic [7:0] REG_0F    = 8'h0F;

    localparam logic [7:0] RESP_IOCON = 8'h28;
    localparam logic [7:0] RESP_0F    = 8'hF9;
    localparam logic [7:0] RESP_IODIR = 8'hE4;

    function automatic logic [7:0] opcode_byte(input logic [2:0] dev, input logic rw);
        return {OPCODE_BASE, dev, rw};
    endfunction

endpackage

// File: rtl/spi_master_mcp23s17_if.sv
// Command port and SPI pins of the MCP23S17 SPI master, bundled.
// Signals:
//   start_i, rw_i, reg_addr_i, wr_data_i - command request (controller -> master)
//   busy_o, done_o, rd_data_o            - status/result (master -> controller)
//   spiClk_o, cs_o, mosi_o               - SPI pins driven by the master
//   miso_i                               - SPI data returned by the slave
// Modports:
//   master - view of the SPI master itself
//   slave  - view of the controller / SPI device on the other side
interface spi_master_mcp23s17_if;

    logic       start_i;
    logic       rw_i;
    logic [7:0] reg_addr_i;
    logic [7:0] wr_data_i;
    logic       busy_o;
    logic       done_o;
    logic [7:0] rd_data_o;
    logic       spiClk_o;
    logic       cs_o;
    logic       mosi_o;
    logic       miso_i;

    modport master (
        input  start_i, rw_i, reg_addr_i, wr_data_i, miso_i,
        output busy_o, done_o, rd_data_o, spiClk_o, cs_o, mosi_o
    );

    modport slave (
        output start_i, rw_i, reg_addr_i, wr_data_i, miso_i,
        input  busy_o, done_o, rd_data_o, spiClk_o, cs_o, mosi_o
    );

endinterface

// File: rtl/spi_master_mcp23s17_timer.sv
// Half-period timer for the SPI master: free-running modulo-CLK_DIV counter.
// Ports:
//   sysClk - system clock
//   reset  - synchronous active-high reset
//   clear  - forces the count back to zero
//   tick   - high in the cycle where the count equals CLK_DIV-1
module spi_half_period_timer #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic sysClk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [7:0] count;

    assign tick = (count == 8'(CLK_DIV - 1));

    // Wrapping on tick lets consecutive phases chain without an explicit clear.
    always_ff @(posedge sysClk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_mcp23s17.sv
// SPI master (mode 0) issuing 3-byte MCP23S17 register transactions:
// opcode {0100, DEV_ADDR, rw}, register address, data (0x00 for reads).
// The third MISO byte of a read is returned on rd_data_o.
// Ports:
//   sysClk - system clock
//   reset  - synchronous active-high reset
//   bus    - command port and SPI pins (spi_master_mcp23s17_if.master)
// Parameters:
//   CLK_DIV  - sysClk cycles per SCLK half-period (4..255)
//   DEV_ADDR - hardware address placed in opcode bits [3:1]
module spi_master_mcp23s17
    import mcp23s17_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 8,
    parameter logic [2:0]  DEV_ADDR = 3'b000
) (
    input  logic                  sysClk,
    input  logic                  reset,
    spi_master_mcp23s17_if.master bus
);

    state_t      state, state_d;
    logic        tick, timer_clear;
    logic [23:0] frame;
    logic [22:0] tx_shift, tx_shift_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic [4:0]  bit_cnt, bit_cnt_d;
    logic        last_bit, last_bit_d;
    logic        rw_q, rw_d;
    logic        sclk_q, sclk_d;
    logic        cs_q, cs_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  rd_q, rd_d;

    assign frame = {opcode_byte(DEV_ADDR, bus.rw_i), bus.reg_addr_i,
                    bus.rw_i ? 8'h00 : bus.wr_data_i};

    spi_half_period_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_timer (
        .sysClk(sysClk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        timer_clear = 1'b0;
        tx_shift_d  = tx_shift;
        rx_shift_d  = rx_shift;
        bit_cnt_d   = bit_cnt;
        last_bit_d  = last_bit;
        rw_d        = rw_q;
        sclk_d      = sclk_q;
        cs_d        = cs_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd_d        = rd_q;

        unique case (state)
            IDLE: begin
                timer_clear = 1'b1;
                busy_d      = 1'b0;
                if (bus.start_i) begin
                    rw_d       = bus.rw_i;
                    tx_shift_d = frame[22:0];
                    mosi_d     = frame[23];
                    cs_d       = 1'b0;
                    bit_cnt_d  = 5'd23;
                    last_bit_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift[6:0], bus.miso_i};
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The SHIFT phase spans 48 half-periods, so after the 24th
                // falling edge it stays for one more low half-period
                // (flagged by last_bit) before handing over to HOLD.
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (bit_cnt == 5'd0) begin
                            last_bit_d = 1'b1;
                        end else begin
                            bit_cnt_d  = bit_cnt - 5'd1;
                            mosi_d     = tx_shift[22];
                            tx_shift_d = {tx_shift[21:0], 1'b0};
                        end
                    end else if (last_bit) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d     = 1'b1;
                        rx_shift_d = {rx_shift[6:0], bus.miso_i};
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                timer_clear = 1'b1;
                done_d      = 1'b1;
                if (rw_q) begin
                    rd_d = rx_shift;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            last_bit <= 1'b0;
            rw_q     <= 1'b0;
            sclk_q   <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= '0;
        end else begin
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            bit_cnt  <= bit_cnt_d;
            last_bit <= last_bit_d;
            rw_q     <= rw_d;
            sclk_q   <= sclk_d;
            cs_q     <= cs_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
        end
    end

    assign bus.spiClk_o  = sclk_q;
    assign bus.cs_o      = cs_q;
    assign bus.mosi_o    = mosi_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.rd_data_o = rd_q;

endmodule

// File: tb/tb_spi_master_mcp23s17.sv
// Testbench for spi_master_mcp23s17.
// Three instances: [0] CLK_DIV=8/DEV_ADDR=0, [1] CLK_DIV=8/DEV_ADDR=5,
// [2] CLK_DIV=4/DEV_ADDR=0. Each has an SPI slave model that captures MOSI,
// counts SCLK edges and answers byte 3 with a register-dependent value.
module tb_spi_master_mcp23s17;
    import mcp23s17_pkg::*;

    logic sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    logic rst0, rst12;
    int unsigned total = 0;
    int unsigned passed = 0;

    spi_master_mcp23s17_if bus [3] ();

    spi_master_mcp23s17 #(.CLK_DIV(8), .DEV_ADDR(3'b000)) u_dut0 (
        .sysClk(sysClk), .reset(rst0), .bus(bus[0]));
    spi_master_mcp23s17 #(.CLK_DIV(8), .DEV_ADDR(3'b101)) u_dut1 (
        .sysClk(sysClk), .reset(rst12), .bus(bus[1]));
    spi_master_mcp23s17 #(.CLK_DIV(4), .DEV_ADDR(3'b000)) u_dut2 (
        .sysClk(sysClk), .reset(rst12), .bus(bus[2]));

    function automatic logic [7:0] resp_for(input int unsigned g, input logic [7:0] op,
                                            input logic [7:0] addr);
        if (g == 2) return 8'hC3;
        if (!op[0]) return 8'hA5;
        case (addr)
            REG_IOCON: return RESP_IOCON;
            REG_0F:    return RESP_0F;
            REG_IODIR: return RESP_IODIR;
            default:   return 8'h00;
        endcase
    endfunction

    // Slave model / monitor, evaluated 2 time units after each rising sysClk.
    for (genvar g = 0; g < 3; g++) begin : g_mon
        int unsigned rises = 0, frames = 0, dones = 0, run = 0, last_rises = 0;
        int unsigned hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
        logic [23:0] shift = '0, last_frame = '0;
        logic [7:0]  resp = '0;
        logic        sclk_p = 1'b0, cs_p = 1'b1, miso_v = 1'b0;

        always @(posedge sysClk) begin
            #2;
            if (bus[g].done_o === 1'b1) dones++;
            if (bus[g].cs_o === 1'b0) begin
                if (bus[g].spiClk_o !== sclk_p) begin
                    if (sclk_p) begin
                        if (run < hi_min) hi_min = run;
                        if (run > hi_max) hi_max = run;
                    end else begin
                        if (run < lo_min) lo_min = run;
                        if (run > lo_max) lo_max = run;
                    end
                    run = 1;
                    if (bus[g].spiClk_o) begin
                        shift = {shift[22:0], bus[g].mosi_o};
                        rises++;
                        if (rises == 16) resp = resp_for(g, shift[15:8], shift[7:0]);
                    end else if (rises >= 16 && rises < 24) begin
                        miso_v = resp[3'(23 - rises)];
                    end
                end else begin
                    run++;
                end
            end else begin
                if (cs_p === 1'b0) begin
                    last_frame = shift;
                    last_rises = rises;
                    frames++;
                end
                rises  = 0;
                run    = 0;
                miso_v = 1'b0;
            end
            bus[g].miso_i = miso_v;
            sclk_p = bus[g].spiClk_o;
            cs_p   = bus[g].cs_o;
        end
    end

    function automatic logic done_of(input int unsigned g);
        case (g)
            0:       return bus[0].done_o;
            1:       return bus[1].done_o;
            default: return bus[2].done_o;
        endcase
    endfunction

    function automatic logic busy_of(input int unsigned g);
        case (g)
            0:       return bus[0].busy_o;
            1:       return bus[1].busy_o;
            default: return bus[2].busy_o;
        endcase
    endfunction

    task automatic set_req(input int unsigned g, input logic s, input logic rw,
                           input logic [7:0] a, input logic [7:0] d);
        case (g)
            0: begin bus[0].start_i = s; bus[0].rw_i = rw; bus[0].reg_addr_i = a; bus[0].wr_data_i = d; end
            1: begin bus[1].start_i = s; bus[1].rw_i = rw; bus[1].reg_addr_i = a; bus[1].wr_data_i = d; end
            default: begin bus[2].start_i = s; bus[2].rw_i = rw; bus[2].reg_addr_i = a; bus[2].wr_data_i = d; end
        endcase
    endtask

    // Call just after a falling sysClk edge; the next rising edge is cycle 0.
    task automatic start_txn(input int unsigned g, input logic rw,
                             input logic [7:0] a, input logic [7:0] d);
        set_req(g, 1'b1, rw, a, d);
        @(posedge sysClk);
        #1;
        set_req(g, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Returns the cycle index at which done_o was seen (0 on timeout).
    task automatic wait_done(input int unsigned g, output int unsigned cyc,
                             output int unsigned busy_n);
        cyc = 0;
        busy_n = 0;
        for (int unsigned i = 1; i <= 3000; i++) begin
            @(negedge sysClk);
            if (busy_of(g)) busy_n++;
            if (done_of(g)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst0 = 1'b1;
        rst12 = 1'b1;
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(2, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(0, 1'b1, 1'b1, 8'h0A, 8'h00);   // start during reset must be ignored
        repeat (3) @(negedge sysClk);
        total++; if (bus[0].cs_o !== 1'b1) $display("FAIL rst_cs got %b want 1", bus[0].cs_o); else passed++;
        total++; if (bus[0].spiClk_o !== 1'b0) $display("FAIL rst_sclk got %b want 0", bus[0].spiClk_o); else passed++;
        total++; if (bus[0].mosi_o !== 1'b0) $display("FAIL rst_mosi got %b want 0", bus[0].mosi_o); else passed++;
        total++; if (bus[0].busy_o !== 1'b0) $display("FAIL rst_busy got %b want 0", bus[0].busy_o); else passed++;
        total++; if (bus[0].done_o !== 1'b0) $display("FAIL rst_done got %b want 0", bus[0].done_o); else passed++;
        total++; if (bus[0].rd_data_o !== 8'h00) $display("FAIL rst_rd got %h want 00", bus[0].rd_data_o); else passed++;
        rst0 = 1'b0;
        rst12 = 1'b0;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge sysClk);
        total++; if (bus[0].cs_o !== 1'b1) $display("FAIL rst_start_cs got %b want 1", bus[0].cs_o); else passed++;
        total++; if (bus[0].busy_o !== 1'b0) $display("FAIL rst_start_busy got %b want 0", bus[0].busy_o); else passed++;
    endtask

    task automatic test_read_iocon;
        int unsigned cyc, bn, d0, f0;
        d0 = g_mon[0].dones;
        f0 = g_mon[0].frames;
        @(negedge sysClk);
        start_txn(0, 1'b1, REG_IOCON, 8'hFF);
        wait_done(0, cyc, bn);
        total++; if (cyc !== 410) $display("FAIL rd_latency got %0d want 410", cyc); else passed++;
        total++; if (bn !== 410) $display("FAIL rd_busy_cycles got %0d want 410", bn); else passed++;
        total++; if (bus[0].rd_data_o !== 8'h28) $display("FAIL rd_iocon got %h want 28", bus[0].rd_data_o); else passed++;
        total++; if (g_mon[0].last_frame !== 24'h410A00) $display("FAIL rd_mosi got %h want 410a00", g_mon[0].last_frame); else passed++;
        total++; if (g_mon[0].last_rises !== 24) $display("FAIL rd_rises got %0d want 24", g_mon[0].last_rises); else passed++;
        repeat (3) @(negedge sysClk);
        total++; if (g_mon[0].frames - f0 !== 1) $display("FAIL rd_frames got %0d want 1", g_mon[0].frames - f0); else passed++;
        total++; if (g_mon[0].dones - d0 !== 1) $display("FAIL rd_done_pulse got %0d want 1", g_mon[0].dones - d0); else passed++;
    endtask

    task automatic test_back_to_back;
        int unsigned cyc, bn;
        @(negedge sysClk);
        start_txn(0, 1'b1, REG_0F, 8'h00);
        wait_done(0, cyc, bn);
        total++; if (bus[0].rd_data_o !== 8'hF9) $display("FAIL b2b_rd0f got %h want f9", bus[0].rd_data_o); else passed++;
        total++; if (g_mon[0].last_frame !== 24'h410F00) $display("FAIL b2b_mosi0f got %h want 410f00", g_mon[0].last_frame); else passed++;
        @(negedge sysClk);
        total++; if (bus[0].busy_o !== 1'b0) $display("FAIL b2b_busy_after got %b want 0", bus[0].busy_o); else passed++;
        start_txn(0, 1'b1, REG_IODIR, 8'h00);
        wait_done(0, cyc, bn);
        total++; if (cyc !== 410) $display("FAIL b2b_latency got %0d want 410", cyc); else passed++;
        total++; if (bus[0].rd_data_o !== 8'hE4) $display("FAIL b2b_rd00 got %h want e4", bus[0].rd_data_o); else passed++;
        total++; if (g_mon[0].last_frame !== 24'h410000) $display("FAIL b2b_mosi00 got %h want 410000", g_mon[0].last_frame); else passed++;
    endtask

    task automatic test_write;
        int unsigned cyc, bn;
        @(negedge sysClk);
        start_txn(0, 1'b0, REG_IODIR, 8'h5A);
        wait_done(0, cyc, bn);
        total++; if (cyc !== 410) $display("FAIL wr_latency got %0d want 410", cyc); else passed++;
        total++; if (bus[0].rd_data_o !== 8'hE4) $display("FAIL wr_rd_hold got %h want e4", bus[0].rd_data_o); else passed++;
        total++; if (g_mon[0].last_frame !== 24'h40005A) $display("FAIL wr_mosi got %h want 40005a", g_mon[0].last_frame); else passed++;
        total++; if (g_mon[0].last_rises !== 24) $display("FAIL wr_rises got %0d want 24", g_mon[0].last_rises); else passed++;
    endtask

    task automatic test_dev_addr_ignore_start;
        int unsigned cyc, bn, d0, f0;
        d0 = g_mon[1].dones;
        f0 = g_mon[1].frames;
        @(negedge sysClk);
        start_txn(1, 1'b1, REG_IOCON, 8'h00);
        repeat (100) @(negedge sysClk);
        start_txn(1, 1'b0, 8'h12, 8'h33);       // lands in SHIFT
        wait_done(1, cyc, bn);
        total++; if (g_mon[1].last_frame !== 24'h4B0A00) $display("FAIL dev_mosi got %h want 4b0a00", g_mon[1].last_frame); else passed++;
        total++; if (bus[1].rd_data_o !== 8'h28) $display("FAIL dev_rd got %h want 28", bus[1].rd_data_o); else passed++;
        repeat (60) @(negedge sysClk);
        total++; if (g_mon[1].frames - f0 !== 1) $display("FAIL ign_frames got %0d want 1", g_mon[1].frames - f0); else passed++;
        total++; if (g_mon[1].dones - d0 !== 1) $display("FAIL ign_dones got %0d want 1", g_mon[1].dones - d0); else passed++;
        total++; if (bus[1].busy_o !== 1'b0) $display("FAIL ign_busy got %b want 0", bus[1].busy_o); else passed++;
    endtask

    task automatic test_reset_mid;
        int unsigned cyc, bn, d0;
        d0 = g_mon[0].dones;
        @(negedge sysClk);
        start_txn(0, 1'b1, REG_IOCON, 8'h00);
        for (int unsigned i = 0; i < 2000; i++) begin
            @(negedge sysClk);
            if (g_mon[0].rises >= 10) break;
        end
        total++; if (g_mon[0].rises !== 10) $display("FAIL mid_rise10 got %0d want 10", g_mon[0].rises); else passed++;
        rst0 = 1'b1;
        @(negedge sysClk);
        total++; if (bus[0].cs_o !== 1'b1) $display("FAIL mid_cs got %b want 1", bus[0].cs_o); else passed++;
        total++; if (bus[0].spiClk_o !== 1'b0) $display("FAIL mid_sclk got %b want 0", bus[0].spiClk_o); else passed++;
        total++; if (bus[0].mosi_o !== 1'b0) $display("FAIL mid_mosi got %b want 0", bus[0].mosi_o); else passed++;
        total++; if (bus[0].busy_o !== 1'b0) $display("FAIL mid_busy got %b want 0", bus[0].busy_o); else passed++;
        total++; if (bus[0].rd_data_o !== 8'h00) $display("FAIL mid_rd got %h want 00", bus[0].rd_data_o); else passed++;
        rst0 = 1'b0;
        repeat (450) @(negedge sysClk);
        total++; if (g_mon[0].dones - d0 !== 0) $display("FAIL mid_no_done got %0d want 0", g_mon[0].dones - d0); else passed++;
        start_txn(0, 1'b1, REG_0F, 8'h00);
        wait_done(0, cyc, bn);
        total++; if (cyc !== 410) $display("FAIL mid_after_latency got %0d want 410", cyc); else passed++;
        total++; if (bus[0].rd_data_o !== 8'hF9) $display("FAIL mid_after_rd got %h want f9", bus[0].rd_data_o); else passed++;
        total++; if (g_mon[0].last_frame !== 24'h410F00) $display("FAIL mid_after_mosi got %h want 410f00", g_mon[0].last_frame); else passed++;
    endtask

    task automatic test_clkdiv4;
        int unsigned cyc, bn;
        @(negedge sysClk);
        start_txn(2, 1'b1, REG_IOCON, 8'h00);
        wait_done(2, cyc, bn);
        total++; if (cyc !== 206) $display("FAIL d4_latency got %0d want 206", cyc); else passed++;
        total++; if (bus[2].rd_data_o !== 8'hC3) $display("FAIL d4_rd got %h want c3", bus[2].rd_data_o); else passed++;
        total++; if (g_mon[2].last_rises !== 24) $display("FAIL d4_rises got %0d want 24", g_mon[2].last_rises); else passed++;
        total++; if (g_mon[2].hi_min !== 4) $display("FAIL d4_hi_min got %0d want 4", g_mon[2].hi_min); else passed++;
        total++; if (g_mon[2].hi_max !== 4) $display("FAIL d4_hi_max got %0d want 4", g_mon[2].hi_max); else passed++;
        total++; if (g_mon[2].lo_min !== 4) $display("FAIL d4_lo_min got %0d want 4", g_mon[2].lo_min); else passed++;
        total++; if (g_mon[2].lo_max !== 4) $display("FAIL d4_lo_max got %0d want 4", g_mon[2].lo_max); else passed++;
    endtask

    initial begin
        test_reset;
        test_read_iocon;
        test_back_to_back;
        test_write;
        test_dev_addr_ignore_start;
        test_reset_mid;
        test_clkdiv4;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish, %0d/%0d passed so far", passed, total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master_mcp23s17.md
Name: spi_master_mcp23s17

Overview:
SPI master that issues MCP23S17-style 3-byte register transactions: opcode, register address, then data. It drives SCLK, /CS and MOSI toward an SPI slave (the on-chip emulator or a real expander) and captures MISO during the third byte. It sits between a simple CPU/test-controller command port and the external SPI pins. It uses SPI mode 0: SCLK idles low, MOSI changes on falling edges, MISO is sampled on rising edges.

Parameters:
CLK_DIV, 8, sysClk cycles per SCLK half-period; legal range 4..255 (the slave needs at least 4 system cycles per half-period because of its 2-flop synchronisers).
DEV_ADDR, 3'b000, hardware address field placed in opcode bits [3:1].

Ports:
sysClk  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
start_i  in  1  single-cycle request; sampled only in IDLE.
rw_i  in  1  1 = read, 0 = write; latched with start_i.
reg_addr_i  in  8  register address byte; latched with start_i.
wr_data_i  in  8  write data byte; latched with start_i; ignored for reads.
busy_o  out  1  high from the cycle after start is accepted until the done cycle, inclusive.
done_o  out  1  one-cycle completion pulse.
rd_data_o  out  8  third MISO byte of the last read; holds its value otherwise.
spiClk_o  out  1  SCLK to the slave.
cs_o  out  1  /CS, active low.
mosi_o  out  1  serial data to the slave.
miso_i  in  1  serial data from the slave; assumed stable around SCLK rising edges.

Behaviour:
- All outputs are registered.
- Reset values: cs_o=1, spiClk_o=0, mosi_o=0, busy_o=0, done_o=0, rd_data_o=8'h00, state=IDLE.
- Opcode byte = {4'b0100, DEV_ADDR, rw_i}. With DEV_ADDR=0: write = 8'h40, read = 8'h41.
- Frame is 24 bits = {opcode, reg_addr_i, rw_i ? 8'h00 : wr_data_i}, sent MSB first.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> DONE -> IDLE.
- IDLE (cycle 0), start_i=1: latch the frame; cs_o<=0; mosi_o<=frame[23]; half-period counter<=0; go to SETUP. A start_i in any other state is ignored and not queued.
- SETUP: CLK_DIV cycles. On the last cycle, spiClk_o<=1 (first rising edge) and go to SHIFT.
- SHIFT: spiClk_o toggles every CLK_DIV cycles, giving 48 half-periods in total.
  - On each 0->1 toggle: rx_shift<={rx_shift[22:0], miso_i}, sampling miso_i in the same cycle.
  - On each 1->0 toggle: advance tx_shift and drive mosi_o with the next bit; decrement a 5-bit bit counter (starts at 23).
  - The 24th falling edge, when the counter is 0, goes to HOLD with spiClk_o=0. mosi_o is not updated after bit 0.
- HOLD: CLK_DIV cycles with /CS still low. Then cs_o<=1, mosi_o<=0, go to GAP.
- GAP: CLK_DIV cycles of minimum /CS-high time. Then go to DONE.
- DONE: one cycle.
  - done_o=1.
  - If the transaction was a read, rd_data_o<=rx_shift[7:0].
  - Writes leave rd_data_o unchanged.
  - Next state is IDLE, and busy_o is 0 the following cycle.
- Latency: done_o is high in cycle 51*CLK_DIV+2, counting the start-accept cycle as 0. A new start_i is accepted the cycle after done.
- SCLK period = 2*CLK_DIV sysClk cycles. Exactly 24 rising and 24 falling SCLK edges occur while /CS is low.
- Reset mid-transaction: next cycle cs_o=1, spiClk_o=0, mosi_o=0, state IDLE, no done_o pulse, rd_data_o cleared to 8'h00.
- start_i and reset in the same cycle: reset wins.

Decomposition:
- Package mcp23s17_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP, DONE);
  - OPCODE_BASE=4'b0100;
  - register constants REG_IODIR=8'h00, REG_IOCON=8'h0A, REG_0F=8'h0F;
  - emulator response constants 8'h28, 8'hF9, 8'hE4, shared with the slave bench.
- One sub-module, spi_half_period_timer (parameter CLK_DIV; inputs sysClk, reset, clear; output tick when the count reaches CLK_DIV-1). It is reused by the FSM for SETUP, SHIFT, HOLD and GAP.

Test Plan:
- Read, CLK_DIV=8, reg 8'h0A, paired with the slave emulator at the same sysClk -> MOSI bytes 41 0A 00; rd_data_o=8'h28; done_o in cycle 410.
- Read of reg 8'h0F -> rd_data_o=8'hF9. Read of reg 8'h00 -> rd_data_o=8'hE4. The two reads are back-to-back, with start_i asserted the cycle after done.
- Write reg 8'h00, data 8'h5A -> MOSI bytes 40 00 5A; rd_data_o keeps its previous value; 24 SCLK rising edges counted while /CS is low.
- DEV_ADDR=3'b101, read -> opcode 8'h4B. start_i pulsed during SHIFT -> ignored: exactly one frame and one done_o.
- Reset asserted at the 10th SCLK rising edge -> next cycle cs_o=1, spiClk_o=0, busy_o=0, no done_o; a subsequent read completes normally.
- CLK_DIV=4, MISO driven by a bench model with pattern 8'hC3 in byte 3 -> rd_data_o=8'hC3; SCLK high and low phases each exactly 4 cycles.
